// File: rtl/eggtimer_pkg.sv
// rtl/eggtimer_pkg.sv - shared state encoding and parameter defaults for the egg timer sequencer
package eggtimer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_e;

  localparam int TICK_DIV_DEF    = 100_000_000;
  localparam int ALARM_TICKS_DEF = 10;

endpackage

// File: rtl/eggtimer_btn_edge.sv
// rtl/eggtimer_btn_edge.sv - two-flop synchroniser with rising-edge pulse for one raw button
module eggtimer_btn_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_edge
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_btn;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_edge = r_sync & ~r_prev;

endmodule

// File: rtl/eggtimer_sequencer.sv
// rtl/eggtimer_sequencer.sv - run-control FSM: button edges, 1 Hz tick prescaler, alarm timing
module eggtimer_sequencer
  import eggtimer_pkg::*;
#(
  parameter int TICK_DIV    = TICK_DIV_DEF,
  parameter int ALARM_TICKS = ALARM_TICKS_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_btn_begin,
  input  logic       i_btn_pause,
  input  logic       i_btn_reset,
  input  logic       i_zero,
  output logic       o_load,
  output logic       o_dec_en,
  output logic       o_countdown,
  output logic       o_paused,
  output logic       o_alarm,
  output logic [1:0] o_state
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int AW = $clog2(ALARM_TICKS + 1);
  localparam logic [PW-1:0] PS_MAX  = PW'(TICK_DIV - 1);
  localparam logic [AW-1:0] AC_LAST = AW'(ALARM_TICKS - 1);

  logic w_begin_edge;
  logic w_pause_edge;
  logic w_reset_edge;

  state_e        r_state;
  logic          r_load;
  logic          r_dec_en;
  logic [PW-1:0] r_presc;
  logic [AW-1:0] r_alarm_cnt;

  eggtimer_btn_edge u_begin (.i_clk(i_clk), .i_rst(i_rst), .i_btn(i_btn_begin), .o_edge(w_begin_edge));
  eggtimer_btn_edge u_pause (.i_clk(i_clk), .i_rst(i_rst), .i_btn(i_btn_pause), .o_edge(w_pause_edge));
  eggtimer_btn_edge u_reset (.i_clk(i_clk), .i_rst(i_rst), .i_btn(i_btn_reset), .o_edge(w_reset_edge));

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= ST_IDLE;
      r_load      <= 1'b0;
      r_dec_en    <= 1'b0;
      r_presc     <= '0;
      r_alarm_cnt <= '0;
    end else begin
      r_load   <= 1'b0;
      r_dec_en <= 1'b0;
      if (w_reset_edge) begin
        r_state     <= ST_IDLE;
        r_load      <= 1'b1;
        r_presc     <= '0;
        r_alarm_cnt <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_presc     <= '0;
            r_alarm_cnt <= '0;
            if (w_begin_edge && !i_zero) r_state <= ST_RUN;
          end
          ST_RUN: begin
            if (i_zero) begin
              r_state <= ST_ALARM;
              r_presc <= '0;
            end else if (w_pause_edge) begin
              r_state <= ST_PAUSE;
            end else if (r_presc == PS_MAX) begin
              r_presc  <= '0;
              r_dec_en <= 1'b1;
            end else begin
              r_presc <= r_presc + 1'b1;
            end
          end
          // Prescaler is frozen here so a resume continues the partial tick.
          ST_PAUSE: begin
            if (w_begin_edge || w_pause_edge) r_state <= ST_RUN;
          end
          ST_ALARM: begin
            if (w_begin_edge || w_pause_edge) begin
              r_state     <= ST_IDLE;
              r_presc     <= '0;
              r_alarm_cnt <= '0;
            end else if (r_presc == PS_MAX) begin
              r_presc <= '0;
              if (r_alarm_cnt == AC_LAST) begin
                r_state     <= ST_IDLE;
                r_alarm_cnt <= '0;
              end else begin
                r_alarm_cnt <= r_alarm_cnt + 1'b1;
              end
            end else begin
              r_presc <= r_presc + 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_load      = r_load;
  assign o_dec_en    = r_dec_en;
  assign o_countdown = (r_state == ST_RUN);
  assign o_paused    = (r_state == ST_PAUSE);
  assign o_alarm     = (r_state == ST_ALARM);
  assign o_state     = r_state;

endmodule

// File: tb/tb_eggtimer_sequencer.sv
// tb/tb_eggtimer_sequencer.sv - directed and randomized bench for eggtimer_sequencer
module tb_eggtimer_sequencer;

  localparam int TICK_DIV    = 4;
  localparam int ALARM_TICKS = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       b_begin, b_pause, b_reset, zero_in;
  logic       o_load, o_dec_en, o_countdown, o_paused, o_alarm;
  logic [1:0] o_state;

  always #5 clk = ~clk;

  eggtimer_sequencer #(.TICK_DIV(TICK_DIV), .ALARM_TICKS(ALARM_TICKS)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_btn_begin(b_begin), .i_btn_pause(b_pause),
    .i_btn_reset(b_reset), .i_zero(zero_in), .o_load(o_load), .o_dec_en(o_dec_en),
    .o_countdown(o_countdown), .o_paused(o_paused), .o_alarm(o_alarm), .o_state(o_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference: button history per edge, states 0..3, elapsed-cycle accounting.
  int         m_st, m_phase, m_acyc;
  logic       m_load, m_dec;
  logic [2:0] h_b, h_p, h_r;

  int         obs_dec = 0, obs_load = 0, obs_paused = 0, obs_run = 0;
  logic [1:0] prev_state = 2'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic model_step();
    logic re, pe, be;
    if (!rst_n) begin
      m_st = 0; m_load = 0; m_dec = 0; m_phase = 0; m_acyc = 0;
      h_b = '0; h_p = '0; h_r = '0;
    end else begin
      re = h_r[1] & ~h_r[2];
      pe = h_p[1] & ~h_p[2];
      be = h_b[1] & ~h_b[2];
      m_load = 0;
      m_dec  = 0;
      if (re) begin
        m_st = 0; m_load = 1; m_phase = 0; m_acyc = 0;
      end else begin
        case (m_st)
          0: if (be && !zero_in) begin m_st = 1; m_phase = 0; end
          1: begin
            if (zero_in) begin m_st = 3; m_acyc = 0; end
            else if (pe) m_st = 2;
            else begin
              m_phase++;
              if (m_phase == TICK_DIV) begin m_phase = 0; m_dec = 1; end
            end
          end
          2: if (be || pe) m_st = 1;
          default: begin
            if (be || pe) begin m_st = 0; m_acyc = 0; end
            else begin
              m_acyc++;
              if (m_acyc == TICK_DIV * ALARM_TICKS) begin m_st = 0; m_acyc = 0; end
            end
          end
        endcase
      end
      h_b = {h_b[1:0], b_begin};
      h_p = {h_p[1:0], b_pause};
      h_r = {h_r[1:0], b_reset};
    end
  endtask

  task automatic cyc(input int n);
    logic [1:0] es;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      #1;
      es = m_st[1:0];
      chk("outs", {25'd0, o_state, o_load, o_dec_en, o_countdown, o_paused, o_alarm},
          {25'd0, es, m_load, m_dec, es == 2'd1, es == 2'd2, es == 2'd3});
      if (o_dec_en) obs_dec++;
      if (o_load) obs_load++;
      if (o_paused) obs_paused++;
      if (o_state == 2'd1 && prev_state != 2'd1) obs_run++;
      prev_state = o_state;
    end
  endtask

  task automatic wait_state(input logic [1:0] s, input int lim, output int t);
    t = 0;
    do begin cyc(1); t++; end while (o_state != s && t <= lim);
  endtask

  task automatic wait_dec(input int lim, output int t);
    t = 0;
    do begin cyc(1); t++; end while (!o_dec_en && t <= lim);
  endtask

  initial begin
    int t, d0, l0, p0, r0;
    rst_n = 0; b_begin = 0; b_pause = 0; b_reset = 0; zero_in = 0;
    cyc(3);
    chk("rst_outs", {28'd0, o_state, o_load, o_dec_en}, 32'd0);
    rst_n = 1;
    cyc(50);
    chk("idle_dec", obs_dec, 0);

    b_begin = 1;
    wait_state(2'd1, 10, t);
    chk("begin_lat", t, 3);
    b_begin = 0;
    wait_dec(10, t); chk("first_tick", t, TICK_DIV);
    wait_dec(10, t); chk("tick2", t, TICK_DIV);
    wait_dec(10, t); chk("tick3", t, TICK_DIV);
    zero_in = 1;
    d0 = obs_dec;
    cyc(1);
    chk("alarm_entry", o_state, 3);
    wait_state(2'd0, 30, t);
    chk("alarm_len", t, TICK_DIV * ALARM_TICKS);
    chk("alarm_drop", o_alarm, 0);
    chk("alarm_no_dec", obs_dec - d0, 0);
    zero_in = 0;
    cyc(2);

    b_begin = 1;
    wait_state(2'd1, 10, t);
    b_begin = 0;
    wait_dec(10, t);
    b_pause = 1;
    wait_state(2'd2, 10, t);
    chk("pause_lat", t, 3);
    d0 = obs_dec;
    cyc(8);
    chk("paused_no_dec", obs_dec - d0, 0);
    b_pause = 0;
    cyc(3);
    b_pause = 1;
    wait_state(2'd1, 10, t);
    wait_dec(10, t);
    chk("resume_tick", t, 2);
    b_pause = 0;

    wait_dec(10, t);
    b_reset = 1; b_pause = 1;
    l0 = obs_load; p0 = obs_paused; d0 = obs_dec;
    cyc(8);
    chk("rp_load", obs_load - l0, 1);
    chk("rp_no_pause", obs_paused - p0, 0);
    chk("rp_no_dec", obs_dec - d0, 0);
    chk("rp_state", o_state, 0);
    b_reset = 0; b_pause = 0;
    cyc(2);

    r0 = obs_run;
    b_begin = 1;
    cyc(20);
    b_begin = 0;
    chk("held_begin", obs_run - r0, 1);
    b_reset = 1;
    cyc(4);
    b_reset = 0;
    chk("back_idle", o_state, 0);

    zero_in = 1; b_begin = 1;
    cyc(6);
    chk("begin_zero", o_state, 0);
    b_begin = 0; zero_in = 0;
    cyc(2);

    b_begin = 1;
    wait_state(2'd1, 10, t);
    b_begin = 0; zero_in = 1;
    cyc(1);
    chk("alarm_enter2", o_state, 3);
    b_begin = 1;
    wait_state(2'd0, 10, t);
    chk("alarm_ack", t, 3);
    b_begin = 0; zero_in = 0;
    cyc(2);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0) b_begin = ~b_begin;
      if ($urandom_range(0, 9) == 0) b_pause = ~b_pause;
      if ($urandom_range(0, 59) == 0) b_reset = ~b_reset;
      if ($urandom_range(0, 24) == 0) zero_in = ~zero_in;
      if (!rst_n) rst_n = 1;
      else if ($urandom_range(0, 799) == 0) rst_n = 0;
      cyc(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/eggtimer_sequencer.md
Name: eggtimer_sequencer

Overview:
Full run-control FSM for the egg timer countdown datapath; it replaces ad-hoc level logic with a clean sequenced controller. It synchronises and edge-detects the begin/pause/reset buttons, generates the 1 Hz decrement enable from an internal prescaler, and drives datapath load/decrement. It also times the end-of-count alarm. It sits between the button inputs and the mm:ss counter datapath, which returns `zero`.

Parameters:
TICK_DIV, 100000000, clk cycles per countdown tick; must be >= 2; prescaler width is clog2(TICK_DIV)
ALARM_TICKS, 10, ticks the alarm stays asserted before auto-return to IDLE; must be >= 1

Ports:
clk  input  1  system clock, single clock domain
rst  input  1  asynchronous, active-low reset
btn_begin  input  1  raw begin/resume button, active high, asynchronous to clk
btn_pause  input  1  raw pause/resume button, active high
btn_reset  input  1  raw reset button, active high
zero  input  1  datapath count == 00:00
load  output  1  one-cycle pulse: datapath reloads the preset value
dec_en  output  1  one-cycle pulse: datapath decrements by one second
countdown  output  1  high while in RUN
paused  output  1  high while in PAUSE
alarm  output  1  high while in ALARM
state  output  2  current FSM state (debug/display)

Behaviour:
- Reset (rst=0, async): state=IDLE, load=0, dec_en=0, prescaler=0, alarm counter=0, all sync/edge flops=0.
- Button path: 2-flop synchroniser plus a previous-value flop per button; edge = sync & ~prev. If the raw button is first sampled high at edge n, the resulting state change and any load pulse take effect at edge n+2. A held button produces exactly one edge.
- States: IDLE=0, RUN=1, PAUSE=2, ALARM=3. All outputs are registered or decoded from state only; there are no combinational input-to-output paths.
- Priority within a cycle: reset_edge > zero (in RUN) > pause_edge > begin_edge > tick.
- Any state, reset_edge: next state IDLE, load=1 for one cycle, prescaler and alarm counter cleared, no dec_en.
- IDLE:
  - begin_edge with zero=0: go to RUN, prescaler cleared.
  - begin_edge with zero=1: stay in IDLE; there is nothing to count.
  - pause_edge: ignored.
- RUN:
  - zero=1: go to ALARM next edge, no dec_en, prescaler cleared.
  - Otherwise pause_edge: go to PAUSE; prescaler holds its value.
  - Otherwise prescaler == TICK_DIV-1: prescaler wraps to 0 and dec_en=1 in the following cycle. A pause in that same cycle suppresses the dec_en.
  - begin_edge: ignored.
- PAUSE:
  - begin_edge or pause_edge: go to RUN; prescaler resumes from its held value, so no partial tick is lost or gained.
  - zero is not evaluated in PAUSE.
- ALARM:
  - alarm=1; prescaler runs and the alarm counter increments on each wrap.
  - When the counter reaches ALARM_TICKS: go to IDLE, counter cleared.
  - begin_edge or pause_edge: acknowledge, go to IDLE immediately.
- Tick spacing: consecutive dec_en pulses in uninterrupted RUN are exactly TICK_DIV cycles apart. The first dec_en after entering RUN arrives TICK_DIV cycles after entry.
- Async reset asserted mid-RUN or mid-ALARM: all state is lost; there is no load pulse from rst itself.

Decomposition:
- Package eggtimer_pkg holds:
  - the state enum (IDLE/RUN/PAUSE/ALARM, 2 bits);
  - the TICK_DIV and ALARM_TICKS defaults.
- One sub-module, eggtimer_btn_edge (synchroniser plus rising-edge detect, clk/rst, in to edge pulse), instantiated three times.
- The prescaler and alarm counter stay inline.

Test Plan (TICK_DIV=4, ALARM_TICKS=3):
- Reset then idle: rst low 3 cycles, release -> state=0; load, dec_en, alarm all 0; no dec_en for 50 cycles.
- Start and count: zero=0, pulse btn_begin -> state=1 two edges after first sample. dec_en pulses every 4 cycles, first one 4 cycles after entry. Drive zero=1 after 3 pulses -> state=3 next edge, alarm=1, no further dec_en.
- Alarm timeout: remain in ALARM with no buttons -> state returns to 0 after exactly 12 cycles; alarm drops in the same cycle.
- Pause/resume: btn_pause 2 cycles after a dec_en -> state=2, no dec_en while held. Resume via btn_pause -> next dec_en exactly 2 cycles after RUN re-entry.
- Reset priority: btn_reset and btn_pause rising together in RUN -> state=0 and a single 1-cycle load pulse; no PAUSE visited, no dec_en.
- Edge cases:
  - btn_begin held 20 cycles in IDLE with zero=0 -> single RUN entry.
  - btn_begin with zero=1 -> stays 0.
  - btn_begin in ALARM -> state=0 next-but-one edge.
